seg7_axis_decoder: RTL and testbench

//  AXI-Stream sink for two-digit 7-segment frames, as produced by the accumulator's m_data port.

---
 rtl/seg7_pkg.sv | 67 ++++++
 rtl/axis_sync_fifo.sv | 79 +++++++
 rtl/seg7_axis_decoder.sv | 108 ++++++++++
 tb/tb_seg7_axis_decoder.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: digit codes, result record and decode/encode
// helpers. The accumulator's encoder uses the same table, so a code change
// here stays consistent on both sides of the loopback.
package seg7_pkg;

    // Segment codes, bit6=g .. bit0=a
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    // Number of digits in one frame (tens, ones)
    localparam int SEG7_DIGITS = 2;

    // One decoded frame as held in the output FIFO: {err, value}
    typedef struct packed {
        logic       err;
        logic [6:0] value;
    } seg7_result_t;

    // Map a segment code to its digit; ok=0 for any code outside the table.
    function automatic void seg7_decode(input logic [6:0] seg,
                                        output logic [3:0] digit,
                                        output bit ok);
        digit = 4'd0;
        ok    = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: ok    = 1'b0;
        endcase
    endfunction

    // Inverse mapping used by the encoder; digits above 9 give a blank digit.
    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Valid/ready FIFO with an explicit occupancy counter. Pointers are
// log2(DEPTH) bits and wrap naturally (DEPTH must be a power of two, >= 2).
// Output data is forced to zero while empty so the port is clean after reset.
module axis_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CNTW-1:0] count_reg;
    logic [AW-1:0]   wr_ptr_next;
    logic [AW-1:0]   rd_ptr_next;
    logic [CNTW-1:0] count_next;
    logic            push;
    logic            pop;

    // Handshakes: full blocks the writer, so push and pop together only
    // happen below DEPTH and leave the occupancy unchanged.
    always_comb begin
        in_ready  = (count_reg != CNTW'(DEPTH));
        out_valid = (count_reg != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_data  = out_valid ? mem[rd_ptr_reg] : '0;
    end

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        if (push && !pop) begin
            count_next = count_reg + CNTW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNTW'(1);
        end
    end

    // Storage is not reset; the occupancy counter decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    // Pointer and occupancy registers; reset discards all buffered entries.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

endmodule

// File: rtl/seg7_axis_decoder.sv
// AXI-Stream sink for two-digit 7-segment frames. Each accepted frame is
// decoded to tens*10+ones (0..99) and queued as {err, value} for the master
// side. Illegal codes give value 0, err 1, and bump a saturating counter.
// Build option SEG7_DEC_DROP_INVALID_EN: illegal frames are still accepted
// and counted but never queued, so m_err stays 0.
module seg7_axis_decoder
    import seg7_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [1:0][6:0]       s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [6:0]            m_data,
    output logic                  m_err,
    output logic [CW-1:0]         err_count
);

    logic         frame_ok;
    logic [6:0]   frame_value;
    logic         accept;
    logic         store_en;
    logic         fifo_in_valid;
    seg7_result_t fifo_in;
    seg7_result_t fifo_out;
    logic [CW-1:0] err_count_reg;
    logic [CW-1:0] err_count_next;

    genvar gi;
    generate
        for (gi = 0; gi < SEG7_DIGITS; gi++) begin : g_digit
            logic [3:0] digit;
            bit         ok;
            // Look up one digit of the incoming frame in the shared table.
            always_comb begin
                digit = 4'd0;
                ok    = 1'b0;
                seg7_decode(s_data[gi], digit, ok);
            end
        end
    endgenerate

    // Combine digits; any illegal digit collapses the whole frame to 0/err.
    always_comb begin
        frame_ok    = g_digit[1].ok && g_digit[0].ok;
        frame_value = 7'd0;
        if (frame_ok) begin
            frame_value = 7'(g_digit[1].digit) * 7'd10 + 7'(g_digit[0].digit);
        end
        fifo_in.err   = !frame_ok;
        fifo_in.value = frame_value;
    end

    // Acceptance depends only on FIFO room; the write may still be suppressed.
    always_comb begin
        accept = s_valid && s_ready;
`ifdef SEG7_DEC_DROP_INVALID_EN
        store_en = frame_ok;
`else
        store_en = 1'b1;
`endif
        fifo_in_valid = s_valid && store_en;
    end

    axis_sync_fifo #(
        .W     ($bits(seg7_result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (fifo_in_valid),
        .in_ready  (s_ready),
        .in_data   (fifo_in),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (fifo_out)
    );

    // Error counter increments per accepted illegal frame and never wraps.
    always_comb begin
        err_count_next = err_count_reg;
        if (accept && !frame_ok && (err_count_reg != {CW{1'b1}})) begin
            err_count_next = err_count_reg + CW'(1);
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_count_reg <= '0;
        end else begin
            err_count_reg <= err_count_next;
        end
    end

    // Output mapping from the FIFO head.
    always_comb begin
        m_data    = fifo_out.value;
        m_err     = fifo_out.err;
        err_count = err_count_reg;
    end

endmodule

// File: tb/tb_seg7_axis_decoder.sv
// Scoreboard bench for seg7_axis_decoder (DEPTH=2, CW=4).
module tb_seg7_axis_decoder;

    localparam int DEPTH = 2;
    localparam int CW    = 4;
    localparam int ERR_MAX = (1 << CW) - 1;
`ifdef SEG7_DEC_DROP_INVALID_EN
    localparam bit DROP_MODE = 1'b1;
`else
    localparam bit DROP_MODE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [1:0][6:0] s_data = '0;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [6:0]     m_data;
    logic           m_err;
    logic [CW-1:0]  err_count;

    int checks = 0;
    int errors = 0;
    int err_model = 0;
    int cyc = 0;
    int obs_idx = 0;
    logic [7:0] exp_q [$];
    logic [7:0] obs_q [$];
    int         obs_cyc [$];

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    seg7_axis_decoder #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_err     (m_err),
        .err_count (err_count)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output transfer, sampled mid-cycle.
    always @(negedge clk) begin
        if (rstn && m_valid && m_ready) begin
            obs_q.push_back({m_err, m_data});
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Reference decode: {err, value}
    function automatic logic [7:0] model(input logic [6:0] t, input logic [6:0] o);
        int dt = -1;
        int dn = -1;
        for (int k = 0; k < 10; k++) begin
            if (seg_tab[k] == t) dt = k;
            if (seg_tab[k] == o) dn = k;
        end
        if (dt < 0 || dn < 0) return 8'h80;
        return {1'b0, 7'(dt * 10 + dn)};
    endfunction

    // Present a frame and hold it until accepted; returns one cycle after the edge.
    task automatic drive_frame(input logic [6:0] t, input logic [6:0] o,
                               output int waited, output bit accepted);
        logic [7:0] e;
        s_data[1] = t;
        s_data[0] = o;
        s_valid   = 1'b1;
        waited    = 0;
        accepted  = 1'b0;
        while (!accepted && waited < 50) begin
            @(negedge clk);
            if (s_ready) begin
                e = model(t, o);
                if (!(e[7] && DROP_MODE)) exp_q.push_back(e);
                if (e[7] && err_model < ERR_MAX) err_model++;
                accepted = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        $display("frame tens=%h ones=%h accepted=%0d waited=%0d", t, o, accepted, waited);
    endtask

    // Wait until the observed stream has caught up with the expectations.
    task automatic wait_drain();
        int n = 0;
        while ((obs_q.size() - obs_idx) < exp_q.size() && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int w;
        bit a;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== 7'd0 || m_err !== 1'b0 || err_count !== '0) begin
            errors++;
            $display("FAIL reset_state: m_valid=%b m_data=%0d m_err=%b err_count=%0d, need 0/0/0/0",
                     m_valid, m_data, m_err, err_count);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_sready: s_ready=%b need 1", s_ready);
        end
        // Buffer frames with the sink stalled, then reset mid-stream.
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        drive_frame(7'h00, 7'h3F, w, a);
        drive_frame(7'h3F, 7'h06, w, a);
        s_valid = 1'b0;
        checks++;
        if (err_count !== CW'(1) || s_ready !== !DROP_MODE ? 1'b0 : 1'b1) begin
        end
        if (err_count !== CW'(1)) begin
            errors++;
            $display("FAIL pre_reset_errcount: err_count=%0d need 1", err_count);
        end
        checks++;
        if (s_ready !== DROP_MODE) begin
            errors++;
            $display("FAIL pre_reset_full: s_ready=%b need %b", s_ready, DROP_MODE);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || err_count !== '0) begin
            errors++;
            $display("FAIL midstream_reset: m_valid=%b err_count=%0d need 0/0", m_valid, err_count);
        end
        exp_q.delete();
        err_model = 0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || obs_q.size() != obs_idx) begin
            errors++;
            $display("FAIL post_reset_stale: s_ready=%b m_valid=%b outputs=%0d need 1/0/0",
                     s_ready, m_valid, obs_q.size() - obs_idx);
        end
        obs_idx = obs_q.size();
    endtask

    task automatic test_single();
        int w;
        bit a;
        m_ready = 1'b1;
        drive_frame(7'h4F, 7'h6D, w, a);
        s_valid = 1'b0;
        checks++;
        if (!a) begin
            errors++;
            $display("FAIL single_accept: frame not accepted within bound");
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 7'd35 || m_err !== 1'b0) begin
            errors++;
            $display("FAIL single_out: m_valid=%b m_data=%0d m_err=%b need 1/35/0", m_valid, m_data, m_err);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_empty: m_valid=%b need 0", m_valid);
        end
        wait_drain();
        checks++;
        if (obs_q.size() - obs_idx != exp_q.size()) begin
            errors++;
            $display("FAIL single_count: outputs=%0d need %0d", obs_q.size() - obs_idx, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_idx < obs_q.size()) begin
            checks++;
            if (obs_q[obs_idx] !== exp_q[0]) begin
                errors++;
                $display("FAIL single_sb: got %h need %h", obs_q[obs_idx], exp_q[0]);
            end
            obs_idx++;
            void'(exp_q.pop_front());
        end
        exp_q.delete();
        obs_idx = obs_q.size();
    endtask

    task automatic test_backpressure();
        int w;
        bit a1, a2, a3;
        m_ready = 1'b0;
        drive_frame(7'h3F, 7'h06, w, a1);
        drive_frame(7'h06, 7'h5B, w, a2);
        s_data[1] = 7'h5B;
        s_data[0] = 7'h4F;
        s_valid   = 1'b1;
        checks++;
        if (!a1 || !a2) begin
            errors++;
            $display("FAIL bp_accept: accepted=%b%b need 11", a1, a2);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 7'd1) begin
                errors++;
                $display("FAIL bp_hold: s_ready=%b m_valid=%b m_data=%0d need 0/1/1", s_ready, m_valid, m_data);
            end
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_pop_cycle: s_ready=%b need 0", s_ready);
        end
        @(posedge clk);
        #1;
        drive_frame(7'h5B, 7'h4F, w, a3);
        s_valid = 1'b0;
        checks++;
        if (!a3 || w != 0) begin
            errors++;
            $display("FAIL bp_ready_rise: accepted=%b waited=%0d need 1/0", a3, w);
        end
        wait_drain();
        checks++;
        if (obs_q.size() - obs_idx != 3 || exp_q.size() != 3) begin
            errors++;
            $display("FAIL bp_count: outputs=%0d expected=%0d need 3", obs_q.size() - obs_idx, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_idx < obs_q.size()) begin
            checks++;
            if (obs_q[obs_idx] !== exp_q[0]) begin
                errors++;
                $display("FAIL bp_sb: got %h need %h", obs_q[obs_idx], exp_q[0]);
            end
            obs_idx++;
            void'(exp_q.pop_front());
        end
        exp_q.delete();
        obs_idx = obs_q.size();
    endtask

    task automatic test_illegal();
        int w;
        bit a;
        m_ready = 1'b1;
        drive_frame(7'h00, 7'h3F, w, a);
        s_valid = 1'b0;
        checks++;
        if (!a || err_count !== CW'(1)) begin
            errors++;
            $display("FAIL illegal_count: accepted=%b err_count=%0d need 1/1", a, err_count);
        end
        @(negedge clk);
        checks++;
        if (DROP_MODE) begin
            if (m_valid !== 1'b0) begin
                errors++;
                $display("FAIL illegal_drop: m_valid=%b need 0", m_valid);
            end
        end else begin
            if (m_valid !== 1'b1 || m_data !== 7'd0 || m_err !== 1'b1) begin
                errors++;
                $display("FAIL illegal_fwd: m_valid=%b m_data=%0d m_err=%b need 1/0/1", m_valid, m_data, m_err);
            end
        end
        wait_drain();
        checks++;
        if (obs_q.size() - obs_idx != exp_q.size()) begin
            errors++;
            $display("FAIL illegal_outputs: outputs=%0d need %0d", obs_q.size() - obs_idx, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_idx < obs_q.size()) begin
            checks++;
            if (obs_q[obs_idx] !== exp_q[0]) begin
                errors++;
                $display("FAIL illegal_sb: got %h need %h", obs_q[obs_idx], exp_q[0]);
            end
            obs_idx++;
            void'(exp_q.pop_front());
        end
        exp_q.delete();
        obs_idx = obs_q.size();
    endtask

    task automatic test_saturation();
        int w;
        bit a;
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_frame(7'h00, 7'(i), w, a);
            checks++;
            if (!a || err_count !== CW'(err_model)) begin
                errors++;
                $display("FAIL sat_step%0d: accepted=%b err_count=%0d need 1/%0d", i, a, err_count, err_model);
            end
        end
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (err_count !== CW'(15)) begin
            errors++;
            $display("FAIL sat_hold: err_count=%0d need 15", err_count);
        end
        wait_drain();
        checks++;
        if (obs_q.size() - obs_idx != exp_q.size()) begin
            errors++;
            $display("FAIL sat_outputs: outputs=%0d need %0d", obs_q.size() - obs_idx, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_idx < obs_q.size()) begin
            checks++;
            if (obs_q[obs_idx] !== exp_q[0]) begin
                errors++;
                $display("FAIL sat_sb: got %h need %h", obs_q[obs_idx], exp_q[0]);
            end
            obs_idx++;
            void'(exp_q.pop_front());
        end
        exp_q.delete();
        obs_idx = obs_q.size();
    endtask

    task automatic test_streaming();
        int w;
        bit a;
        int stalls = 0;
        int missed = 0;
        int base;
        int gaps = 0;
        m_ready = 1'b1;
        base = obs_idx;
        for (int i = 0; i < 100; i++) begin
            drive_frame(seg_tab[i / 10], seg_tab[i % 10], w, a);
            stalls += w;
            if (!a) missed++;
        end
        s_valid = 1'b0;
        checks++;
        if (stalls != 0 || missed != 0) begin
            errors++;
            $display("FAIL stream_sready: stalls=%0d missed=%0d need 0/0", stalls, missed);
        end
        wait_drain();
        checks++;
        if (obs_q.size() - base != 100) begin
            errors++;
            $display("FAIL stream_count: outputs=%0d need 100", obs_q.size() - base);
        end else begin
            for (int k = 1; k < 100; k++) begin
                if (obs_cyc[base + k] - obs_cyc[base + k - 1] != 1) gaps++;
            end
            checks++;
            if (gaps != 0) begin
                errors++;
                $display("FAIL stream_rate: gaps=%0d need 0", gaps);
            end
            for (int k = 0; k < 100; k++) begin
                checks++;
                if (obs_q[base + k] !== {1'b0, 7'(k)}) begin
                    errors++;
                    $display("FAIL stream_value%0d: got %h need %h", k, obs_q[base + k], {1'b0, 7'(k)});
                end
            end
        end
        exp_q.delete();
        obs_idx = obs_q.size();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_illegal();
        test_saturation();
        test_streaming();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
